// File: rtl/cmp_result_filter_if.sv
// Bundle of comparator flags (in) and committed, debounced results (out).
// Latency: none, wiring only.
// Backpressure: none, level signals only.
//   master: drives a_gt_b/a_lt_b/a_eq_b and observes the results (upstream side / bench)
//   slave : consumes the flags and drives res_*, res_valid, change_strobe,
//           change_count and illegal (the filter)
interface cmp_result_filter_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 a_gt_b;
    logic                 a_lt_b;
    logic                 a_eq_b;
    logic                 res_gt;
    logic                 res_lt;
    logic                 res_eq;
    logic                 res_valid;
    logic                 change_strobe;
    logic [CNT_WIDTH-1:0] change_count;
    logic                 illegal;

    modport master (
        output a_gt_b, a_lt_b, a_eq_b,
        input  res_gt, res_lt, res_eq, res_valid, change_strobe, change_count, illegal
    );

    modport slave (
        input  a_gt_b, a_lt_b, a_eq_b,
        output res_gt, res_lt, res_eq, res_valid, change_strobe, change_count, illegal
    );
endinterface

// File: rtl/cmp_result_filter.sv
// Synchronise and debounce comparator flags; commit a pattern after STABLE_CYCLES stable clocks.
// Latency: pattern held from before edge E0 shows on res_*/change_strobe at edge E0+STABLE_CYCLES+2.
// Backpressure: none; all outputs are registered levels plus a one-cycle change strobe.
//   Ports: clk, rst (async, active-high), bus (cmp_result_filter_if.slave).
module cmp_result_filter #(
    parameter int STABLE_CYCLES = 12000,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                clk,
    input  logic                rst,
    cmp_result_filter_if.slave  bus
);
    localparam int              SCW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [SCW-1:0]  STAB_MAX = SCW'(STABLE_CYCLES - 1);

    localparam logic [1:0] CODE_EQ  = 2'b00;
    localparam logic [1:0] CODE_GT  = 2'b01;
    localparam logic [1:0] CODE_LT  = 2'b10;
    localparam logic [1:0] CODE_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // flag vectors are ordered {gt, lt, eq}
    logic [2:0]           sync1_q;
    logic [2:0]           sync2_q;
    logic [2:0]           prime_q;
    logic [1:0]           s;
    logic [1:0]           cand_q;
    logic [SCW-1:0]       stab_q;
    logic [1:0]           code_q;
    state_t               state_q;
    state_t               state_d;
    logic                 fresh;
    logic                 qualified;
    logic                 commit;
    logic                 ill_set;
    logic                 ill_clr;
    logic                 res_gt_q;
    logic                 res_lt_q;
    logic                 res_eq_q;
    logic                 res_valid_q;
    logic                 strobe_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 illegal_q;

    // Two-flop synchronisers on the asynchronous flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prime_q <= '0;
        end else begin
            sync1_q <= {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b};
            sync2_q <= sync1_q;
            prime_q <= {prime_q[1:0], 1'b1};
        end
    end

    // The synchroniser's reset contents are not a real sample. Until the first
    // captured sample has been loaded as a fresh candidate, counting is held at
    // zero, so nothing can qualify earlier than STABLE_CYCLES+2 edges after reset.
    assign fresh = ~prime_q[2];

    always_comb begin
        case (sync2_q)
            3'b100:  s = CODE_GT;
            3'b010:  s = CODE_LT;
            3'b001:  s = CODE_EQ;
            default: s = CODE_ILL;
        endcase
    end

    // Candidate tracking: any change of s restarts the count; count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q <= CODE_ILL;
            stab_q <= '0;
        end else if (fresh || (s != cand_q)) begin
            cand_q <= s;
            stab_q <= '0;
        end else if (stab_q != STAB_MAX) begin
            stab_q <= stab_q + SCW'(1);
        end
    end

    assign qualified = ~fresh && (s == cand_q) && (stab_q == STAB_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        ill_set = 1'b0;
        ill_clr = 1'b0;

        if (qualified) begin
            if (cand_q == CODE_ILL) begin
                ill_set = 1'b1;
            end else begin
                ill_clr = 1'b1;
                commit  = (state_q == ST_EMPTY) || (cand_q != code_q);
            end
        end

        case (state_q)
            ST_EMPTY:  if (commit) state_d = ST_HOLD;
            ST_HOLD: begin
                // with STABLE_CYCLES = 1 a new candidate can commit straight from HOLD
                if (commit)                    state_d = ST_HOLD;
                else if (cand_q != code_q)     state_d = ST_SETTLE;
            end
            ST_SETTLE: if (commit || (cand_q == code_q)) state_d = ST_HOLD;
            default:   state_d = ST_EMPTY;
        endcase
    end

    // Committed result and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q      <= CODE_EQ;
            res_gt_q    <= 1'b0;
            res_lt_q    <= 1'b0;
            res_eq_q    <= 1'b0;
            res_valid_q <= 1'b0;
            strobe_q    <= 1'b0;
            count_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            strobe_q <= commit;
            if (commit) begin
                code_q      <= cand_q;
                res_gt_q    <= (cand_q == CODE_GT);
                res_lt_q    <= (cand_q == CODE_LT);
                res_eq_q    <= (cand_q == CODE_EQ);
                res_valid_q <= 1'b1;
                count_q     <= count_q + CNT_WIDTH'(1);
            end
            if (ill_set)      illegal_q <= 1'b1;
            else if (ill_clr) illegal_q <= 1'b0;
        end
    end

    assign bus.res_gt        = res_gt_q;
    assign bus.res_lt        = res_lt_q;
    assign bus.res_eq        = res_eq_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.change_strobe = strobe_q;
    assign bus.change_count  = count_q;
    assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_cmp_result_filter.sv
// Self-checking bench for cmp_result_filter with STABLE_CYCLES = 4, CNT_WIDTH = 3.
// Latency: expected commits land 6 edges after a pattern is applied.
// Backpressure: none; commits are scoreboarded and popped on change_strobe.
module tb_cmp_result_filter;
    localparam int STABLE = 4;
    localparam int CW     = 3;

    typedef struct packed {
        logic          gt;
        logic          lt;
        logic          eq;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    cmp_result_filter_if #(.CNT_WIDTH(CW)) bus ();

    cmp_result_filter #(
        .STABLE_CYCLES(STABLE),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // {gt, lt, eq, valid, strobe, count[2:0], illegal}
    function automatic logic [8:0] obs();
        return {bus.res_gt, bus.res_lt, bus.res_eq, bus.res_valid,
                bus.change_strobe, bus.change_count, bus.illegal};
    endfunction

    function automatic logic [8:0] ev(input logic gt, input logic lt, input logic eq,
                                      input logic vld, input logic stb,
                                      input logic [CW-1:0] cnt, input logic ill);
        return {gt, lt, eq, vld, stb, cnt, ill};
    endfunction

    function automatic exp_t mk(input logic gt, input logic lt, input logic eq,
                                input logic [CW-1:0] cnt);
        exp_t e;
        e.gt = gt; e.lt = lt; e.eq = eq; e.cnt = cnt;
        return e;
    endfunction

    // Scoreboard side: every strobe must match the oldest expected commit.
    always @(posedge clk) begin
        #1;
        if (bus.change_strobe === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_strobe: got unexpected commit gt/lt/eq=%b%b%b count=%0d, required no strobe",
                         bus.res_gt, bus.res_lt, bus.res_eq, bus.change_count);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.res_gt, bus.res_lt, bus.res_eq, bus.change_count} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_commit: got %b, required %b",
                             {bus.res_gt, bus.res_lt, bus.res_eq, bus.change_count}, mon_e);
                end
            end
        end
    end

    task automatic set_flags(input logic [2:0] f);
        {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called at edge+1: asserts rst, holds it two edges, releases between edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        ticks(2);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        set_flags(3'b000);
        #1 rst = 1'b1;
        #2;
        checks++;
        if (obs() !== 9'd0) begin
            errors++; $display("FAIL reset_async: got %b, required %b", obs(), 9'd0);
        end
        ticks(2);
        checks++;
        if (obs() !== 9'd0) begin
            errors++; $display("FAIL reset_held: got %b, required %b", obs(), 9'd0);
        end
    endtask

    task automatic test_first_commit();
        set_flags(3'b001);
        #2 rst = 1'b0;
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 3'd1));
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (obs() !== 9'd0) begin
                errors++; $display("FAIL first_pre_e%0d: got %b, required %b", i - 1, obs(), 9'd0);
            end
        end
        tick();
        checks++;
        if (obs() !== ev(0, 0, 1, 1, 1, 3'd1, 0)) begin
            errors++; $display("FAIL first_commit: got %b, required %b", obs(), ev(0, 0, 1, 1, 1, 3'd1, 0));
        end
        tick();
        checks++;
        if (obs() !== ev(0, 0, 1, 1, 0, 3'd1, 0)) begin
            errors++; $display("FAIL first_strobe_drop: got %b, required %b", obs(), ev(0, 0, 1, 1, 0, 3'd1, 0));
        end
    endtask

    task automatic test_glitch();
        set_flags(3'b100);
        ticks(3);
        set_flags(3'b001);
        ticks(12);
        checks++;
        if (obs() !== ev(0, 0, 1, 1, 0, 3'd1, 0)) begin
            errors++; $display("FAIL glitch_reject: got %b, required %b", obs(), ev(0, 0, 1, 1, 0, 3'd1, 0));
        end
    endtask

    task automatic test_illegal();
        set_flags(3'b110);
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (obs() !== ev(0, 0, 1, 1, 0, 3'd1, 0)) begin
                errors++; $display("FAIL ill_pre_e%0d: got %b, required %b", i - 1, obs(), ev(0, 0, 1, 1, 0, 3'd1, 0));
            end
        end
        tick();
        checks++;
        if (obs() !== ev(0, 0, 1, 1, 0, 3'd1, 1)) begin
            errors++; $display("FAIL ill_set: got %b, required %b", obs(), ev(0, 0, 1, 1, 0, 3'd1, 1));
        end
        ticks(3);
        set_flags(3'b010);
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 3'd2));
        ticks(6);
        checks++;
        if (obs() !== ev(0, 0, 1, 1, 0, 3'd1, 1)) begin
            errors++; $display("FAIL ill_hold: got %b, required %b", obs(), ev(0, 0, 1, 1, 0, 3'd1, 1));
        end
        tick();
        checks++;
        if (obs() !== ev(0, 1, 0, 1, 1, 3'd2, 0)) begin
            errors++; $display("FAIL ill_recover: got %b, required %b", obs(), ev(0, 1, 0, 1, 1, 3'd2, 0));
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [CW-1:0] want;
        set_flags(3'b100);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            want = CW'(i + 1);
            if (i % 2 == 0) begin
                set_flags(3'b100);
                sb.push_back(mk(1'b1, 1'b0, 1'b0, want));
            end else begin
                set_flags(3'b010);
                sb.push_back(mk(1'b0, 1'b1, 1'b0, want));
            end
            ticks(10);
            checks++;
            if (bus.change_count !== want || sb.size() != 0) begin
                errors++; $display("FAIL wrap_%0d: got count=%0d pending=%0d, required count=%0d pending=0",
                                   i, bus.change_count, sb.size(), want);
            end
        end
    endtask

    task automatic test_async_reset();
        set_flags(3'b010);
        ticks(4);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 9'd0) begin
            errors++; $display("FAIL arst_immediate: got %b, required %b", obs(), 9'd0);
        end
        ticks(2);
        #2 rst = 1'b0;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 3'd1));
        ticks(6);
        checks++;
        if (obs() !== 9'd0) begin
            errors++; $display("FAIL arst_no_early: got %b, required %b", obs(), 9'd0);
        end
        tick();
        checks++;
        if (obs() !== ev(0, 1, 0, 1, 1, 3'd1, 0)) begin
            errors++; $display("FAIL arst_recommit: got %b, required %b", obs(), ev(0, 1, 0, 1, 1, 3'd1, 0));
        end
        tick();
    endtask

    task automatic test_zero_flags();
        set_flags(3'b000);
        do_reset();
        ticks(6);
        checks++;
        if (obs() !== 9'd0) begin
            errors++; $display("FAIL zero_pre: got %b, required %b", obs(), 9'd0);
        end
        tick();
        checks++;
        if (obs() !== ev(0, 0, 0, 0, 0, 3'd0, 1)) begin
            errors++; $display("FAIL zero_ill: got %b, required %b", obs(), ev(0, 0, 0, 0, 0, 3'd0, 1));
        end
        ticks(5);
        checks++;
        if (obs() !== ev(0, 0, 0, 0, 0, 3'd0, 1) || sb.size() != 0) begin
            errors++; $display("FAIL zero_hold: got %b pending=%0d, required %b pending=0",
                               obs(), sb.size(), ev(0, 0, 0, 0, 0, 3'd0, 1));
        end
    endtask

    initial begin
        test_reset();
        test_first_commit();
        test_glitch();
        test_illegal();
        test_wrap();
        test_async_reset();
        test_zero_flags();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
